stack_behavioural: RTL and testbench
====================================

Name: stack_behavioural

Overview:
Synchronous LIFO stack, 8 entries x 4 bits, register-file storage. Push writes `data_in` to the top; pop presents the top entry on a registered `data_out`. `full` and `empty` flags let the producer and consumer gate their requests. General-purpose scratch/return-address storage block.

Parameters:
- DATA_WIDTH, 4, width of each entry and of `data_in`/`data_out`.
- DEPTH, 8, number of entries. Must be at least 2.
- CNT_W, $clog2(DEPTH+1) = 4, width of the occupancy counter and `count` port.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstN  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  value to push.
- push  input  1  push request, sampled on the rising clk edge.
- pop  input  1  pop request, sampled on the rising clk edge.
- data_out  output  DATA_WIDTH  registered; last popped value.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rstN=0, asynchronous, overrides everything): count=0, data_out=0, empty=1, full=0.
  - Storage array contents are don't-care and need not be reset.
  - Reset during any operation aborts it immediately.
- `full` and `empty` are decoded combinationally from the registered count. They have no extra latency.
- Push only (push=1, pop=0):
  - If !full: mem[count] <= data_in; count <= count+1.
  - If full: ignored. Memory, count and data_out are unchanged.
- Pop only (push=0, pop=1):
  - If !empty: data_out <= mem[count-1]; count <= count-1. The new data_out is visible after that same edge (1-cycle latency).
  - If empty: ignored. data_out holds its previous value.
- Push and pop together:
  - If empty: treated as push only. data_out is unchanged.
  - Otherwise (including full): data_out <= mem[count-1]; mem[count-1] <= data_in; count is unchanged (swap-top).
- Neither asserted: all state holds. data_out keeps its last popped value indefinitely.
- Requests are level-sampled. A request held for N edges performs N operations.
- No wrap-around. The stack pointer saturates at 0 and DEPTH via the ignore rules above.
- No X propagation from unwritten entries is possible, because only written locations are ever read.

Optional Feature:
- Macro: STACK_ERR_FLAGS_EN.
- When defined, two extra output ports are added, each 1 bit:
  - overflow: registered 1-cycle pulse on any edge where push=1, pop=0 and full=1.
  - underflow: registered 1-cycle pulse on any edge where pop=1, push=0 and empty=1.
  - Both reset to 0.
- When not defined, these ports and their logic do not exist. Ignored requests are silently dropped.

Test Plan:
- Reset: hold rstN=0 for 10 ns with clk running -> data_out=0000, count=0, empty=1, full=0. Drive push=1 while in reset -> no change.
- Fill: push 0001, 0010, ... 1000 on 8 separate edges -> count steps 1..8; empty falls after the first push; full=1 after the 8th.
- Overflow: push 1111 while full -> count stays 8, and a later pop returns 1000, not 1111. With STACK_ERR_FLAGS_EN, overflow pulses for exactly one cycle.
- Drain: 8 single-cycle pops -> data_out sequence 1000, 0111, 0110, 0101, 0100, 0011, 0010, 0001; full drops after the first pop; empty=1 after the 8th.
- Underflow: pop while empty -> data_out holds 0001, count stays 0. With STACK_ERR_FLAGS_EN, underflow pulses for one cycle.
- Simultaneous push and pop:
  - On empty, push=pop=1 with data_in=1010 -> count=1, data_out stays 0001, and the next pop returns 1010.
  - Then push 0011, then push=pop=1 with data_in=1100 -> data_out=0011, count stays 2, and the next pop returns 1100.

Source files
------------

// File: rtl/stack_behavioural.sv
// stack_behavioural -- synchronous LIFO stack with register-file storage.
//
// Each storage entry is a small sub-module instantiated once per slot in a
// generate loop; the top holds the occupancy counter, the registered read
// port and the request decode.
//
// Ports:
//   clk       in   rising-edge clock
//   rstN      in   asynchronous active-low reset
//   data_in   in   [DATA_WIDTH] value to push
//   push      in   push request (level-sampled)
//   pop       in   pop request (level-sampled)
//   data_out  out  [DATA_WIDTH] registered, last popped value
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  [CNT_W] occupancy 0..DEPTH
//   overflow  out  (STACK_ERR_FLAGS_EN only) 1-cycle pulse on push-only while full
//   underflow out  (STACK_ERR_FLAGS_EN only) 1-cycle pulse on pop-only while empty
//
// Optional feature macro: STACK_ERR_FLAGS_EN

// One storage slot. Contents are never reset: a slot is only read after it
// has been written.
module stack_entry #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module stack_behavioural #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
`ifdef STACK_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [DEPTH-1:0]                 we_vec;
  logic [CNT_W-1:0]                 cnt_m1;
  logic [AW-1:0]                    top_idx;
  logic [AW-1:0]                    wr_addr;
  logic                             grow, shrink, swap, wr_en, rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Index of the current top entry; only meaningful when not empty.
  assign cnt_m1  = count - CNT_W'(1);
  assign top_idx = cnt_m1[AW-1:0];

  // push+pop on an empty stack degenerates to a plain push; on any
  // non-empty stack (including full) it swaps the top entry in place.
  assign grow   = push & ~full & (~pop | empty);
  assign shrink = pop & ~push & ~empty;
  assign swap   = push & pop & ~empty;

  assign wr_en   = grow | swap;
  assign rd_en   = shrink | swap;
  // When grow is set the stack is not full, so count fits in AW bits.
  assign wr_addr = swap ? top_idx : count[AW-1:0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign we_vec[i] = wr_en && (wr_addr == AW'(i));
    stack_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
      .clk (clk),
      .we  (we_vec[i]),
      .d   (data_in),
      .q   (mem_q[i])
    );
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count    <= '0;
      data_out <= '0;
    end else begin
      if (grow)        count <= count + CNT_W'(1);
      else if (shrink) count <= cnt_m1;
      // Swap reads the old top: the slot write lands on the same edge.
      if (rd_en) data_out <= mem_q[top_idx];
    end
  end

`ifdef STACK_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push & ~pop & full;
      underflow <= pop & ~push & empty;
    end
  end
`endif

endmodule

// File: tb/tb_stack_behavioural.sv
// Randomized + directed bench for stack_behavioural. A queue-based model
// tracks the stack; a negedge process compares every output each cycle, and
// directed steps pin the model with literal expectations.
module tb_stack_behavioural;
  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk  = 1'b0;
  logic          rstN = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          push = 1'b0;
  logic          pop  = 1'b0;
  logic [DW-1:0] data_out;
  logic          full, empty;
  logic [CW-1:0] count;
`ifdef STACK_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  int checks = 0;
  int errors = 0;

  stack_behavioural #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .data_in  (data_in),
    .push     (push),
    .pop      (pop),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .count    (count)
`ifdef STACK_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_stk[$];
  logic [DW-1:0] m_dout;
  bit            m_ovf, m_unf;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_stk.delete();
      m_dout = '0;
      m_ovf  = 0;
      m_unf  = 0;
    end else begin
      m_ovf = push && !pop && (m_stk.size() == DEPTH);
      m_unf = pop && !push && (m_stk.size() == 0);
      if (push && pop) begin
        if (m_stk.size() == 0) m_stk.push_back(data_in);
        else begin
          m_dout = m_stk.pop_back();
          m_stk.push_back(data_in);
        end
      end else if (push) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(data_in);
      end else if (pop) begin
        if (m_stk.size() > 0) m_dout = m_stk.pop_back();
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("count", 32'(count), 32'(m_stk.size()));
    chk("full", 32'(full), 32'(m_stk.size() == DEPTH));
    chk("empty", 32'(empty), 32'(m_stk.size() == 0));
`ifdef STACK_ERR_FLAGS_EN
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
`endif
  end

  task automatic step(input bit p, input bit q, input logic [DW-1:0] d);
    data_in = d;
    push    = p;
    pop     = q;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with push asserted: must not change anything.
    rstN = 1'b0;
    push = 1'b1;
    data_in = 4'h5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(data_out), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    push = 1'b0;
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // Fill 1..8
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, DW'(i));
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_empty", 32'(empty), 32'h0);
    end
    chk("fill_full", 32'(full), 32'h1);

    // Overflow: push while full is dropped
    step(1, 0, 4'hF);
    chk("ovf_count", 32'(count), 32'h8);
`ifdef STACK_ERR_FLAGS_EN
    chk("ovf_pulse", 32'(overflow), 32'h1);
    step(0, 0, 4'h0);
    chk("ovf_clear", 32'(overflow), 32'h0);
`endif

    // Drain: expect 8,7,...,1
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 4'h0);
      chk("drain_dout", 32'(data_out), 32'(DEPTH - i));
      if (i == 0) chk("drain_full", 32'(full), 32'h0);
    end
    chk("drain_empty", 32'(empty), 32'h1);

    // Underflow: pop while empty holds data_out
    step(0, 1, 4'h0);
    chk("unf_dout", 32'(data_out), 32'h1);
    chk("unf_count", 32'(count), 32'h0);
`ifdef STACK_ERR_FLAGS_EN
    chk("unf_pulse", 32'(underflow), 32'h1);
    step(0, 0, 4'h0);
    chk("unf_clear", 32'(underflow), 32'h0);
`endif

    // Simultaneous push/pop on empty acts as push
    step(1, 1, 4'hA);
    chk("pp_empty_count", 32'(count), 32'h1);
    chk("pp_empty_dout", 32'(data_out), 32'h1);
    step(1, 0, 4'h3);
    chk("push3_count", 32'(count), 32'h2);
    step(1, 1, 4'hC);
    chk("swap_dout", 32'(data_out), 32'h3);
    chk("swap_count", 32'(count), 32'h2);
    step(0, 1, 4'h0);
    chk("pop_swapped", 32'(data_out), 32'hC);
    step(0, 1, 4'h0);
    chk("pop_first", 32'(data_out), 32'hA);

    // Swap while full
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i + 2));
    step(1, 1, 4'hE);
    chk("swap_full_dout", 32'(data_out), 32'h9);
    chk("swap_full_count", 32'(count), 32'h8);
    step(0, 1, 4'h0);
    chk("swap_full_pop", 32'(data_out), 32'hE);

    // Randomized traffic with occasional asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rstN = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
      end
      // Bias towards push or pop in phases so both boundaries are hit.
      if (n % 400 < 200)
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, DW'($urandom));
      else
        step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, DW'($urandom));
    end

    push = 1'b0;
    pop  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
